axi_adc_jesd204_pnmon: RTL and testbench

- Receive-side PN sequence monitor for one ADC channel of the JESD204 ADC core, fed with per-channel link data after deframing.
- It is the counterpart to the DAC core's PN/DDS pattern source: it checks PN9/PN23 test patterns sent by the converter and reports out-of-sync and error status to up_adc_channel.
- It handles DATA_PATH_WIDTH 16-bit samples per adc_clk cycle and is self-synchronizing.

---
 rtl/axi_adc_jesd204_pkg.sv | 68 ++++++
 rtl/axi_adc_jesd204_pn_pred.sv | 62 ++++++
 rtl/axi_adc_jesd204_pnmon.sv | 139 +++++++++++++
 tb/tb_axi_adc_jesd204_pnmon.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_adc_jesd204_pkg.sv
// Shared PN pattern definitions for the JESD204 ADC monitor and the DAC pattern source.
// Beats are packed 16 bits per sample; serial order is s0[15]..s0[0], s1[15].., sample 0 first.
package axi_adc_jesd204_pkg;

    localparam logic [3:0] PNSEQ_PN9  = 4'd0;
    localparam logic [3:0] PNSEQ_PN23 = 4'd1;

    localparam int PN9_TAP_A  = 9;
    localparam int PN9_TAP_B  = 5;
    localparam int PN23_TAP_A = 23;
    localparam int PN23_TAP_B = 18;

    localparam int PN_HIST_W  = 23;
    localparam int MAX_BEAT_W = 128;

    typedef logic [MAX_BEAT_W-1:0] beat_t;
    typedef logic [PN_HIST_W-1:0]  hist_t;

    typedef enum logic {
        ST_OOS  = 1'b0,
        ST_SYNC = 1'b1
    } pnmon_state_t;

    function automatic logic [6:0] serial_pos(int k);
        return 7'(16 * (k / 16) + 15 - (k % 16));
    endfunction

    // History bit 0 is the most recent serial bit.
    function automatic hist_t pn_hist_push(hist_t hist, beat_t beat, int width);
        hist_t h;
        h = hist;
        for (int k = 0; k < MAX_BEAT_W; k++) begin
            if (k < width) begin
                h = {h[PN_HIST_W-2:0], beat[serial_pos(k)]};
            end
        end
        return h;
    endfunction

    function automatic beat_t pn_extend(hist_t src, int width, int tap_a, int tap_b);
        hist_t      h;
        beat_t      r;
        logic       nb;
        logic [4:0] ia;
        logic [4:0] ib;
        h  = src;
        r  = '0;
        ia = 5'(tap_a - 1);
        ib = 5'(tap_b - 1);
        for (int k = 0; k < MAX_BEAT_W; k++) begin
            if (k < width) begin
                nb                 = h[ia] ^ h[ib];
                r[serial_pos(k)]   = nb;
                h                  = {h[PN_HIST_W-2:0], nb};
            end
        end
        return r;
    endfunction

    function automatic beat_t pn9_next(hist_t src, int width);
        return pn_extend(src, width, PN9_TAP_A, PN9_TAP_B);
    endfunction

    function automatic beat_t pn23_next(hist_t src, int width);
        return pn_extend(src, width, PN23_TAP_A, PN23_TAP_B);
    endfunction

endpackage

// File: rtl/axi_adc_jesd204_pn_pred.sv
// Registered PN predictor: holds the expected value of the next valid beat.
// Learns from received data while unlocked, free-runs on its own prediction while locked.
module axi_adc_jesd204_pn_pred
    import axi_adc_jesd204_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          valid_i,
    input  logic                          reseed_i,
    input  logic                          use_pred_i,
    input  logic [3:0]                    sel_i,
    input  logic [16*DATA_PATH_WIDTH-1:0] data_i,
    output beat_t                         pred_o,
    output logic                          seeded_o
);

    localparam int W = 16 * DATA_PATH_WIDTH;

    hist_t hist_q, hist_d;
    beat_t pred_q, pred_d;
    logic  seeded_q, seeded_d;
    beat_t src_ext;

    always_comb begin
        hist_d   = hist_q;
        pred_d   = pred_q;
        seeded_d = seeded_q;
        src_ext  = '0;
        if (reseed_i) begin
            seeded_d = 1'b0;
        end
        if (valid_i) begin
            // A beat arriving with a reseed request becomes the new seed.
            if (reseed_i || !seeded_q || !use_pred_i) begin
                src_ext = beat_t'(data_i);
            end else begin
                src_ext = pred_q;
            end
            hist_d   = pn_hist_push(hist_q, src_ext, W);
            pred_d   = (sel_i == PNSEQ_PN23) ? pn23_next(hist_d, W) : pn9_next(hist_d, W);
            seeded_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q   <= '0;
            pred_q   <= '0;
            seeded_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            pred_q   <= pred_d;
            seeded_q <= seeded_d;
        end
    end

    assign pred_o   = pred_q;
    assign seeded_o = seeded_q;

endmodule

// File: rtl/axi_adc_jesd204_pnmon.sv
// PN9/PN23 receive monitor for one JESD204 ADC channel: two-stage pipeline,
// lock FSM with hysteresis counter, and a saturating error counter.
module axi_adc_jesd204_pnmon
    import axi_adc_jesd204_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4,
    parameter int OOS_THRESHOLD   = 16
) (
    input  logic                          adc_clk,
    input  logic                          adc_rst,
    input  logic                          adc_valid,
    input  logic [16*DATA_PATH_WIDTH-1:0] adc_data,
    input  logic [3:0]                    adc_pnseq_sel,
    input  logic                          adc_pn_err_clr,
    output logic                          adc_pn_oos,
    output logic                          adc_pn_err,
    output logic [15:0]                   adc_pn_err_cnt
);

    localparam int         W   = 16 * DATA_PATH_WIDTH;
    localparam logic [8:0] TH9 = 9'(OOS_THRESHOLD);

    logic [3:0]    sel_q;
    logic          sel_chg;
    logic          sel_rsvd;
    logic          reseed;
    logic          oos_entry;
    beat_t         pred_beat;
    logic          seeded;

    logic [W-1:0]  data_s1_q;
    beat_t         pred_s1_q;
    logic          cmp_s1_q;

    pnmon_state_t  state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          oos_q;
    logic          err_q, err_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic          beat_match;
    logic          cnt_hit;

    assign sel_chg  = (adc_pnseq_sel != sel_q);
    assign sel_rsvd = (adc_pnseq_sel != PNSEQ_PN9) && (adc_pnseq_sel != PNSEQ_PN23);
    assign reseed   = sel_chg | sel_rsvd | oos_entry;

    axi_adc_jesd204_pn_pred #(
        .DATA_PATH_WIDTH(DATA_PATH_WIDTH)
    ) u_pred (
        .clk_i      (adc_clk),
        .rst_i      (adc_rst),
        .valid_i    (adc_valid),
        .reseed_i   (reseed),
        .use_pred_i (state_q == ST_SYNC),
        .sel_i      (adc_pnseq_sel),
        .data_i     (adc_data),
        .pred_o     (pred_beat),
        .seeded_o   (seeded)
    );

    // All-zero beats never match so idle links cannot lock.
    assign beat_match = (beat_t'(data_s1_q) == pred_s1_q) && (|data_s1_q);
    assign cnt_hit    = (({1'b0, cnt_q} + 9'd1) == TH9);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        oos_entry = 1'b0;
        if (sel_chg || sel_rsvd) begin
            state_d = ST_OOS;
            cnt_d   = '0;
        end else if (cmp_s1_q) begin
            unique case (state_q)
                ST_OOS: begin
                    if (!beat_match) begin
                        cnt_d = '0;
                    end else if (cnt_hit) begin
                        state_d = ST_SYNC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_SYNC: begin
                    if (beat_match) begin
                        cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if (cnt_hit) begin
                            state_d   = ST_OOS;
                            cnt_d     = '0;
                            oos_entry = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
        if (adc_pn_err_clr) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            sel_q     <= PNSEQ_PN9;
            data_s1_q <= '0;
            pred_s1_q <= '0;
            cmp_s1_q  <= 1'b0;
            state_q   <= ST_OOS;
            cnt_q     <= '0;
            oos_q     <= 1'b1;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            sel_q     <= adc_pnseq_sel;
            data_s1_q <= adc_data;
            pred_s1_q <= pred_beat;
            cmp_s1_q  <= adc_valid & seeded & ~reseed;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            oos_q     <= (state_d == ST_OOS);
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign adc_pn_oos     = oos_q;
    assign adc_pn_err     = err_q;
    assign adc_pn_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_axi_adc_jesd204_pnmon.sv
// Directed bench for the PN monitor; PN streams come from a serial-bit model of the recurrences.
module tb_axi_adc_jesd204_pnmon;

    localparam int DPW = 4;
    localparam int TH  = 16;
    localparam int W   = 16 * DPW;

    logic          adc_clk = 1'b0;
    logic          adc_rst = 1'b1;
    logic          adc_valid = 1'b0;
    logic [W-1:0]  adc_data = '0;
    logic [3:0]    adc_pnseq_sel = 4'd0;
    logic          adc_pn_err_clr = 1'b0;
    logic          adc_pn_oos;
    logic          adc_pn_err;
    logic [15:0]   adc_pn_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int err_seen = 0;
    int gmode = 9;
    bit sb[$];

    axi_adc_jesd204_pnmon #(
        .DATA_PATH_WIDTH(DPW),
        .OOS_THRESHOLD  (TH)
    ) dut (
        .adc_clk        (adc_clk),
        .adc_rst        (adc_rst),
        .adc_valid      (adc_valid),
        .adc_data       (adc_data),
        .adc_pnseq_sel  (adc_pnseq_sel),
        .adc_pn_err_clr (adc_pn_err_clr),
        .adc_pn_oos     (adc_pn_oos),
        .adc_pn_err     (adc_pn_err),
        .adc_pn_err_cnt (adc_pn_err_cnt)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled on the falling edge, where inputs also change.
    task automatic tick();
        @(negedge adc_clk);
        if (adc_pn_err === 1'b1) err_seen++;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d);
        adc_valid = v;
        adc_data  = d;
        tick();
    endtask

    task automatic gen_seed(input int mode);
        gmode = mode;
        sb.delete();
        for (int i = 0; i < 23; i++) sb.push_back(bit'($urandom_range(0, 1)));
        sb[22] = 1'b1;
    endtask

    task automatic gen_beat(output logic [W-1:0] b);
        int n;
        bit nb;
        b = '0;
        for (int k = 0; k < W; k++) begin
            n  = sb.size();
            nb = (gmode == 9) ? (sb[n-9] ^ sb[n-5]) : (sb[n-23] ^ sb[n-18]);
            sb.push_back(nb);
            if (sb.size() > 32) void'(sb.pop_front());
            b[6'(16 * (k / 16) + 15 - (k % 16))] = nb;
        end
    endtask

    task automatic send_pn(input int count);
        logic [W-1:0] b;
        for (int i = 0; i < count; i++) begin
            gen_beat(b);
            drive(1'b1, b);
        end
    endtask

    function automatic logic [W-1:0] rand_mask();
        logic [W-1:0] m;
        m = {$urandom, $urandom};
        if (m == '0) m = 64'd1;
        return m;
    endfunction

    initial begin
        logic [W-1:0] b;
        int e0;

        tick();
        tick();
        adc_rst = 1'b0;
        check("rst_oos", 32'(adc_pn_oos), 32'd1);
        check("rst_err", 32'(adc_pn_err), 32'd0);
        check("rst_errcnt", 32'(adc_pn_err_cnt), 32'd0);

        // PN9 lock: 1 seed + 16 matches
        gen_seed(9);
        send_pn(17);
        check("pn9_lock_pre", 32'(adc_pn_oos), 32'd1);
        send_pn(1);
        check("pn9_lock", 32'(adc_pn_oos), 32'd0);
        check("pn9_lock_noerr", 32'(err_seen), 32'd0);
        check("pn9_lock_errcnt", 32'(adc_pn_err_cnt), 32'd0);

        // single bit flip: bit 5 of sample 2
        send_pn(5);
        e0 = err_seen;
        gen_beat(b);
        b[37] = ~b[37];
        drive(1'b1, b);
        check("flip_err_early", 32'(adc_pn_err), 32'd0);
        send_pn(1);
        check("flip_err_pulse", 32'(adc_pn_err), 32'd1);
        send_pn(1);
        check("flip_err_single", 32'(adc_pn_err), 32'd0);
        send_pn(3);
        check("flip_err_count", 32'(err_seen - e0), 32'd1);
        check("flip_errcnt", 32'(adc_pn_err_cnt), 32'd1);
        check("flip_oos", 32'(adc_pn_oos), 32'd0);

        // valid toggling, invalid beats carry garbage
        e0 = err_seen;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) begin
                gen_beat(b);
                drive(1'b1, b);
            end else begin
                drive(1'b0, rand_mask());
            end
        end
        send_pn(2);
        check("vtog_noerr", 32'(err_seen - e0), 32'd0);
        check("vtog_oos", 32'(adc_pn_oos), 32'd0);
        check("vtog_errcnt", 32'(adc_pn_err_cnt), 32'd1);

        // switch to PN23 mid-stream
        e0 = err_seen;
        gen_seed(23);
        gen_beat(b);
        adc_pnseq_sel = 4'd1;
        drive(1'b1, b);
        check("sel_oos", 32'(adc_pn_oos), 32'd1);
        send_pn(16);
        check("pn23_lock_pre", 32'(adc_pn_oos), 32'd1);
        send_pn(1);
        check("pn23_lock", 32'(adc_pn_oos), 32'd0);
        check("pn23_noerr", 32'(err_seen - e0), 32'd0);
        check("sel_keeps_errcnt", 32'(adc_pn_err_cnt), 32'd1);

        // clear, then all-zero beats while locked on PN23
        adc_pn_err_clr = 1'b1;
        send_pn(1);
        adc_pn_err_clr = 1'b0;
        check("clr_errcnt", 32'(adc_pn_err_cnt), 32'd0);
        send_pn(3);
        e0 = err_seen;
        for (int i = 0; i < 16; i++) drive(1'b1, '0);
        check("zero_oos_pre", 32'(adc_pn_oos), 32'd0);
        drive(1'b1, '0);
        check("zero_oos", 32'(adc_pn_oos), 32'd1);
        check("zero_err_last", 32'(adc_pn_err), 32'd1);
        for (int i = 0; i < 5; i++) drive(1'b1, '0);
        check("zero_err_count", 32'(err_seen - e0), 32'd16);
        check("zero_errcnt", 32'(adc_pn_err_cnt), 32'd16);

        // relock PN23, then preload the error counter to saturation
        send_pn(20);
        check("relock_oos", 32'(adc_pn_oos), 32'd0);
        adc_pn_err_clr = 1'b1;
        send_pn(1);
        adc_pn_err_clr = 1'b0;
        check("preload_clr", 32'(adc_pn_err_cnt), 32'd0);
        e0 = err_seen;
        for (int blk = 0; blk < 4369; blk++) begin
            for (int i = 0; i < 15; i++) begin
                gen_beat(b);
                drive(1'b1, b ^ rand_mask());
            end
            send_pn(1);
        end
        send_pn(2);
        check("preload_errcnt", 32'(adc_pn_err_cnt), 32'h0000FFFF);
        check("preload_pulses", 32'(err_seen - e0), 32'd65535);
        check("preload_oos", 32'(adc_pn_oos), 32'd0);
        gen_beat(b);
        drive(1'b1, b ^ rand_mask());
        send_pn(2);
        check("sat_errcnt", 32'(adc_pn_err_cnt), 32'h0000FFFF);
        check("sat_pulses", 32'(err_seen - e0), 32'd65536);
        gen_beat(b);
        drive(1'b1, b ^ rand_mask());
        gen_beat(b);
        adc_pn_err_clr = 1'b1;
        drive(1'b1, b);
        adc_pn_err_clr = 1'b0;
        check("errclr_pulse", 32'(adc_pn_err), 32'd1);
        check("errclr_cnt", 32'(adc_pn_err_cnt), 32'd0);
        send_pn(2);
        check("errclr_cnt_hold", 32'(adc_pn_err_cnt), 32'd0);

        // reserved selection holds OOS without errors
        e0 = err_seen;
        adc_pnseq_sel = 4'd7;
        send_pn(1);
        check("rsvd_oos_now", 32'(adc_pn_oos), 32'd1);
        send_pn(30);
        for (int i = 0; i < 4; i++) drive(1'b1, '0);
        check("rsvd_oos_hold", 32'(adc_pn_oos), 32'd1);
        check("rsvd_noerr", 32'(err_seen - e0), 32'd0);

        // back to PN9, one error, then reset mid-stream
        adc_pnseq_sel = 4'd0;
        gen_seed(9);
        send_pn(20);
        check("pn9_again_lock", 32'(adc_pn_oos), 32'd0);
        gen_beat(b);
        drive(1'b1, b ^ rand_mask());
        send_pn(2);
        check("pre_rst_errcnt", 32'(adc_pn_err_cnt), 32'd1);
        #2;
        adc_rst = 1'b1;
        #1;
        check("midrst_oos", 32'(adc_pn_oos), 32'd1);
        check("midrst_errcnt", 32'(adc_pn_err_cnt), 32'd0);
        check("midrst_err", 32'(adc_pn_err), 32'd0);
        tick();
        adc_rst = 1'b0;
        send_pn(17);
        check("postrst_lock_pre", 32'(adc_pn_oos), 32'd1);
        send_pn(1);
        check("postrst_lock", 32'(adc_pn_oos), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
